// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - PRBS15 (x^15+x^14+1) self-synchronising byte-stream checker with lock/error tracking
// Optional: define PRBS_CHK_ERR_SAT_EN for a saturating err_cnt (wraps otherwise).
module prbs_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  input  logic             clear,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_pulse,
  output logic             err_sticky
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [14:0]       lfsr_q, lfsr_d;
  logic [7:0]        match_q, match_d;
  logic [7:0]        bad_q, bad_d;
  logic [ERR_W-1:0]  cnt_d;
  logic              pulse_d, sticky_d;
  logic [7:0]        pred;
  logic [7:0]        diff;
  logic [3:0]        nerr;
  logic [ERR_W-1:0]  err_add;

  // Eight LFSR steps from s; first generated bit lands in bit 7.
  function automatic logic [7:0] predict(input logic [14:0] s);
    logic [14:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = {t[13:0], t[14] ^ t[13]};
    return t[7:0];
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] x);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, x[i]};
    return c;
  endfunction

  assign pred = predict(lfsr_q);
  assign diff = data_in ^ pred;
  assign nerr = popcount8(diff);

`ifdef PRBS_CHK_ERR_SAT_EN
  logic [ERR_W:0] sum_ext;
  assign sum_ext = {1'b0, err_cnt} + (ERR_W+1)'(nerr);
  assign err_add = sum_ext[ERR_W] ? {ERR_W{1'b1}} : sum_ext[ERR_W-1:0];
`else
  assign err_add = err_cnt + ERR_W'(nerr);
`endif

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    match_d  = match_q;
    bad_d    = bad_q;
    cnt_d    = err_cnt;
    pulse_d  = 1'b0;
    sticky_d = err_sticky;
    if (valid_in) begin
      case (state_q)
        SEARCH: begin
          // Self-sync: the received bits become the next LFSR state.
          lfsr_d = {lfsr_q[6:0], data_in};
          if (diff == 8'd0 && lfsr_q != 15'd0) match_d = match_q + 8'd1;
          else                                 match_d = 8'd0;
          if (match_d == 8'(LOCK_CNT)) begin
            state_d = LOCKED;
            bad_d   = 8'd0;
          end
        end
        LOCKED: begin
          // Free-run so line errors never corrupt the reference.
          lfsr_d = {lfsr_q[6:0], pred};
          if (nerr != 4'd0) begin
            cnt_d    = err_add;
            pulse_d  = 1'b1;
            sticky_d = 1'b1;
            bad_d    = bad_q + 8'd1;
            if (bad_d == 8'(UNLOCK_CNT)) begin
              state_d = SEARCH;
              match_d = 8'd0;
            end
          end else begin
            bad_d = 8'd0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (clear) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= SEARCH;
      lfsr_q     <= 15'd0;
      match_q    <= 8'd0;
      bad_q      <= 8'd0;
      err_cnt    <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      match_q    <= match_d;
      bad_q      <= bad_d;
      err_cnt    <= cnt_d;
      err_pulse  <= pulse_d;
      err_sticky <= sticky_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed self-checking bench for prbs_checker
module tb_prbs_checker;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        clear;
  logic        locked;
  logic [15:0] err_cnt;
  logic        err_pulse;
  logic        err_sticky;
  logic        s_locked;
  logic [3:0]  s_err_cnt;
  logic        s_err_pulse;
  logic        s_err_sticky;

  int checks = 0;
  int errors = 0;
  logic [14:0] ref_s;
  logic [7:0]  b;
  logic [31:0] exp_small;

  always #5 CLK = ~CLK;

  prbs_checker #(.LOCK_CNT(4), .UNLOCK_CNT(4), .ERR_W(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .data_in(data_in), .valid_in(valid_in), .clear(clear),
    .locked(locked), .err_cnt(err_cnt), .err_pulse(err_pulse), .err_sticky(err_sticky)
  );

  // Narrow counter instance on the same stream, for the wrap/saturate case.
  prbs_checker #(.LOCK_CNT(4), .UNLOCK_CNT(4), .ERR_W(4)) dut_small (
    .CLK(CLK), .RSTn(RSTn), .data_in(data_in), .valid_in(valid_in), .clear(clear),
    .locked(s_locked), .err_cnt(s_err_cnt), .err_pulse(s_err_pulse), .err_sticky(s_err_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_ref(output logic [7:0] o);
    for (int i = 0; i < 8; i++) begin
      ref_s = {ref_s[13:0], ref_s[14] ^ ref_s[13]};
    end
    o = ref_s[7:0];
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic c);
    data_in  = d;
    valid_in = v;
    clear    = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTn     = 1'b0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    clear    = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_sticky", err_sticky, 0);

    // Clean lock: 2 fill bytes + 4 matches
    ref_s = 15'h7FFF;
    next_ref(b);
    chk("first_ref_byte", b, 8'h00);
    step(b, 1, 0);
    for (int i = 0; i < 4; i++) begin
      next_ref(b);
      step(b, 1, 0);
    end
    chk("no_lock_after_5", locked, 0);
    next_ref(b); step(b, 1, 0);
    chk("lock_after_6", locked, 1);
    chk("clean_err_cnt", err_cnt, 0);
    chk("clean_sticky", err_sticky, 0);

    // Single-bit error
    next_ref(b); step(b, 1, 0);
    next_ref(b); step(b ^ 8'h01, 1, 0);
    chk("sb_pulse", err_pulse, 1);
    chk("sb_err_cnt", err_cnt, 1);
    chk("sb_sticky", err_sticky, 1);
    chk("sb_locked", locked, 1);
    next_ref(b); step(b, 1, 0);
    chk("sb_pulse_one_cycle", err_pulse, 0);
    chk("sb_err_cnt_hold", err_cnt, 1);

    // Clear, then an 8-bit corruption
    next_ref(b); step(b, 1, 1);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_sticky", err_sticky, 0);
    next_ref(b); step(b ^ 8'hFF, 1, 0);
    chk("ff_err_cnt", err_cnt, 8);

    // Loss of lock after 4 consecutive errored bytes
    next_ref(b); step(b, 1, 1);
    for (int i = 0; i < 3; i++) begin
      next_ref(b);
      step(b ^ 8'h80, 1, 0);
    end
    chk("lol_still_locked_3", locked, 1);
    next_ref(b); step(b ^ 8'h80, 1, 0);
    chk("lol_unlocked", locked, 0);
    chk("lol_err_cnt", err_cnt, 4);
    for (int i = 0; i < 6; i++) begin
      next_ref(b);
      step(b, 1, 0);
    end
    chk("relock_within_6", locked, 1);
    chk("relock_err_cnt", err_cnt, 4);

    // Clear coincident with an errored byte: clear wins, pulse still fires
    next_ref(b); step(b ^ 8'h01, 1, 1);
    chk("clrerr_err_cnt", err_cnt, 0);
    chk("clrerr_sticky", err_sticky, 0);
    chk("clrerr_pulse", err_pulse, 1);

    // Saturation / wrap on the narrow instance
    next_ref(b); step(b, 1, 1);
    for (int i = 0; i < 3; i++) begin
      next_ref(b);
      step(b ^ 8'hFF, 1, 0);
    end
`ifdef PRBS_CHK_ERR_SAT_EN
    exp_small = 32'd15;
`else
    exp_small = 32'd8;
`endif
    chk("sat_small_err_cnt", s_err_cnt, exp_small);
    chk("sat_wide_err_cnt", err_cnt, 24);
    chk("sat_locked", locked, 1);

    // Gaps: valid every other cycle, idle data is garbage
    do_reset();
    ref_s = 15'h7FFF;
    for (int i = 0; i < 6; i++) begin
      next_ref(b);
      step(b, 1, 0);
      if (i == 4) chk("gap_no_lock_5", locked, 0);
      if (i == 5) chk("gap_lock_6", locked, 1);
      step(8'hA5, 0, 0);
    end
    chk("gap_idle_hold", locked, 1);
    chk("gap_err_cnt", err_cnt, 0);

    // Asynchronous reset mid-stream
    #2 RSTn = 1'b0;
    #1;
    chk("async_rst_locked", locked, 0);
    @(posedge CLK);
    #1 RSTn = 1'b1;

    // All-zero stream never locks
    for (int i = 0; i < 100; i++) begin
      step(8'h00, 1, 0);
      chk("zero_no_lock", locked, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side companion to the PRBS generator. It accepts a byte stream carrying a PRBS15 (x^15 + x^14 + 1) sequence and self-synchronises its local LFSR to that stream. Once synchronised it reports lock, counts bit errors, and drops lock after sustained corruption. It sits at the far end of the link or loopback path and is used for link bring-up and BER measurement.

## Interface
- LOCK_CNT, 4: consecutive matching bytes needed to enter LOCKED (1..255)
- UNLOCK_CNT, 4: consecutive errored bytes needed to leave LOCKED (1..255)
- ERR_W, 16: width of the bit-error counter

- CLK  in  1  clock; all state updates on the rising edge
- RSTn  in  1  reset, asynchronous, active-low
- data_in  in  8  received PRBS byte; bit 7 is the earliest bit in the sequence
- valid_in  in  1  data_in is sampled when high; idle cycles are ignored
- clear  in  1  synchronous clear of err_cnt and err_sticky
- locked  out  1  high while the FSM is in LOCKED
- err_cnt  out  ERR_W  accumulated bit errors while LOCKED
- err_pulse  out  1  one-cycle pulse for each errored byte while LOCKED
- err_sticky  out  1  set on the first error while LOCKED; held until clear or reset

## Operation
- LFSR state s[14:0]. One bit step: b = s[14]^s[13]; s <= {s[13:0], b}. Eight steps form a predicted byte p, with the first bit in p[7].
- States: SEARCH and LOCKED. Reset enters SEARCH with s=0, match_cnt=0, bad_cnt=0.
- SEARCH, on each valid byte:
  - Compare data_in with p computed from the current s.
  - Reload s <= {s[6:0], data_in}. This is the self-sync step.
  - If data_in==p and s!=0 before the byte, match_cnt++. Otherwise match_cnt=0. The all-zero state never counts toward lock.
  - When match_cnt reaches LOCK_CNT: go to LOCKED, clear bad_cnt.
- LOCKED, on each valid byte:
  - s <= {s[6:0], p}. The LFSR free-runs, so received errors are not fed back.
  - e = popcount(data_in ^ p).
  - If e!=0: err_cnt += e, pulse err_pulse, set err_sticky, bad_cnt++.
  - If e==0: bad_cnt=0.
  - When bad_cnt reaches UNLOCK_CNT: go to SEARCH, clear match_cnt. That byte's errors are still counted.
- err_cnt wraps modulo 2^ERR_W. See Configuration for the saturating variant.
- clear in the same cycle as an errored byte: clear wins, and that byte's errors are discarded. err_pulse still fires.
- valid_in low: no state, counter or LFSR change.

## Timing
- Reset values: locked=0, err_cnt=0, err_pulse=0, err_sticky=0. Reset mid-stream aborts immediately and re-enters SEARCH.
- All outputs are registered.
  - locked rises in the cycle after the LOCK_CNT-th matching byte is sampled.
  - locked falls in the cycle after the UNLOCK_CNT-th consecutive errored byte is sampled.
  - err_cnt, err_pulse and err_sticky update in the cycle after the errored byte is sampled.
- One byte per cycle sustained throughput, no backpressure.
- Minimum lock time from reset with a clean stream: 2 + LOCK_CNT valid bytes.
  - Two bytes fill the 15-bit state.
  - The first byte's comparison runs against s=0 and never counts.

## Configuration
- PRBS_CHK_ERR_SAT_EN
  - Defined: err_cnt saturates at 2^ERR_W-1. An addition that would overflow yields all-ones, and the counter holds there until clear or reset.
  - Undefined: err_cnt wraps modulo 2^ERR_W.

## Test plan
- Clean lock: reset, then a reference PRBS15 seeded s=15'h7FFF (first byte 8'h00) streamed with valid_in=1 -> locked=1 in the cycle after byte 2+LOCK_CNT=6; err_cnt=0; err_sticky=0.
- Single-bit error: after lock, XOR 8'h01 into one byte -> one err_pulse, err_cnt=1, err_sticky=1, locked stays 1. An 8'hFF corruption instead -> err_cnt=8.
- Loss of lock: after lock, corrupt 4 consecutive bytes (data_in ^ 8'h80) -> locked=0 in the cycle after the 4th; err_cnt=4; a clean stream then relocks after 6 bytes.
- All-zero input: 100 bytes of 8'h00 with valid_in=1 -> locked stays 0 throughout.
- Gaps and clear: clean stream with valid_in toggling every cycle -> locks after 6 valid bytes. clear coincident with an errored byte -> err_cnt=0 next cycle, err_sticky=0, err_pulse=1.
- Saturation: ERR_W=4 with PRBS_CHK_ERR_SAT_EN defined, 3 bytes XOR 8'hFF -> err_cnt=15. Without the macro -> err_cnt=8 (24 mod 16).
